// File: rtl/ram_ctrl_pkg.sv
// Shared defaults and request type for the ram_syn initiator-side controller.
package ram_ctrl_pkg;

   localparam int DEF_ADDR_W     = 10;
   localparam int DEF_DATA_W     = 8;
   localparam int DEF_RD_LAT     = 1;
   localparam int DEF_RESP_DEPTH = 4;

   typedef struct packed {
      logic                  we;
      logic [DEF_ADDR_W-1:0] addr;
      logic [DEF_DATA_W-1:0] wdata;
   } ram_req_t;

endpackage

// File: rtl/resp_fifo.sv
// Synchronous response FIFO holding returned read data until the host takes it.
module resp_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic [W-1:0]               wdata,
   input  logic                       pop,
   output logic [W-1:0]               rdata,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;

   // DEPTH is a power of two, so the pointers wrap without extra logic.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (!push && pop) count_d = count_q - 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= wdata;
   end

   assign rdata = mem_q[rd_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/ram_access_ctrl.sv
// Issues host write/read requests to ram_syn one per cycle and returns read data in order.
module ram_access_ctrl
   import ram_ctrl_pkg::*;
#(
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int DATA_W     = DEF_DATA_W,
   parameter int RD_LAT     = DEF_RD_LAT,
   parameter int RESP_DEPTH = DEF_RESP_DEPTH
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_rdata,
   output logic [DATA_W-1:0] mem_din,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_w_en,
   input  logic [DATA_W-1:0] mem_dout
);

   localparam int CW = $clog2(RESP_DEPTH) + 1;

   // Handshakes: a transfer happens on a rising edge where valid && ready;
   // valid never waits on ready, and req_ready depends only on free credits.

   logic [CW-1:0]     credits_q, credits_d;
   logic [RD_LAT:0]   rd_pipe_q, rd_pipe_d;
   logic              mem_w_en_q, mem_w_en_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_din_q, mem_din_d;
   logic [CW-1:0]     fifo_count;
   logic              req_fire, rd_fire, pop, push;

   assign req_ready = (credits_q != '0);
   assign req_fire  = req_valid && req_ready;
   assign rd_fire   = req_fire && !req_we;
   assign pop       = resp_valid && resp_ready;
   assign push      = rd_pipe_q[RD_LAT];

   // A credit covers one FIFO slot from read accept until that data is popped,
   // so the FIFO can never be pushed while full.
   always_comb begin
      credits_d = credits_q;
      if (rd_fire && !pop)      credits_d = credits_q - 1'b1;
      else if (!rd_fire && pop) credits_d = credits_q + 1'b1;
   end

   always_comb begin
      rd_pipe_d[0] = rd_fire;
      for (int i = 1; i <= RD_LAT; i++) rd_pipe_d[i] = rd_pipe_q[i-1];
   end

   always_comb begin
      mem_w_en_d = 1'b0;
      mem_addr_d = mem_addr_q;
      mem_din_d  = mem_din_q;
      if (req_fire) begin
         mem_w_en_d = req_we;
         mem_addr_d = req_addr;
         mem_din_d  = req_wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         credits_q  <= CW'(RESP_DEPTH);
         rd_pipe_q  <= '0;
         mem_w_en_q <= 1'b0;
         mem_addr_q <= '0;
         mem_din_q  <= '0;
      end else begin
         credits_q  <= credits_d;
         rd_pipe_q  <= rd_pipe_d;
         mem_w_en_q <= mem_w_en_d;
         mem_addr_q <= mem_addr_d;
         mem_din_q  <= mem_din_d;
      end
   end

   resp_fifo #(
      .DEPTH (RESP_DEPTH),
      .W     (DATA_W)
   ) u_resp_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .wdata (mem_dout),
      .pop   (pop),
      .rdata (resp_rdata),
      .count (fifo_count)
   );

   assign resp_valid = (fifo_count != '0);
   assign mem_w_en   = mem_w_en_q;
   assign mem_addr   = mem_addr_q;
   assign mem_din    = mem_din_q;

endmodule
